// File: rtl/mmu_tlb_map.sv
// Address mapper: kseg0/kseg1 direct mapping plus a fully associative dual-page TLB
// shared by NUM_PORTS registered lookup ports, with CP0 TLBP/TLBR/TLBWI/TLBWR and Random.
module mmu_tlb_map #(
    parameter int NUM_PORTS   = 2,
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ASID_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    lk_en,
    input  logic [NUM_PORTS*32-1:0] lk_vaddr,
    input  logic [NUM_PORTS-1:0]    lk_store,
    input  logic                    user_mode,
    input  logic                    kseg0_uncached,
    input  logic [ASID_W-1:0]       cur_asid,
    output logic [NUM_PORTS-1:0]    lk_valid,
    output logic [NUM_PORTS*32-1:0] lk_paddr,
    output logic [NUM_PORTS-1:0]    lk_uncached,
    output logic [NUM_PORTS-1:0]    lk_addr_err,
    output logic [NUM_PORTS-1:0]    lk_refill,
    output logic [NUM_PORTS-1:0]    lk_invalid,
    output logic [NUM_PORTS-1:0]    lk_modified,
    input  logic [1:0]              tlb_op,
    input  logic                    tlb_op_valid,
    input  logic [31:0]             entryhi_i,
    input  logic [31:0]             entrylo0_i,
    input  logic [31:0]             entrylo1_i,
    input  logic [IDX_W-1:0]        index_i,
    input  logic [IDX_W-1:0]        wired_i,
    input  logic                    wired_we,
    output logic                    tlb_done,
    output logic [31:0]             probe_index_o,
    output logic [31:0]             entryhi_o,
    output logic [31:0]             entrylo0_o,
    output logic [31:0]             entrylo1_o,
    output logic [IDX_W-1:0]        random_o
);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;
    localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

    logic [18:0]       vpn2_q [TLB_ENTRIES];
    logic [18:0]       vpn2_d [TLB_ENTRIES];
    logic [ASID_W-1:0] asid_q [TLB_ENTRIES];
    logic [ASID_W-1:0] asid_d [TLB_ENTRIES];
    logic [19:0]       pfn0_q [TLB_ENTRIES];
    logic [19:0]       pfn0_d [TLB_ENTRIES];
    logic [19:0]       pfn1_q [TLB_ENTRIES];
    logic [19:0]       pfn1_d [TLB_ENTRIES];
    logic [2:0]        c0_q   [TLB_ENTRIES];
    logic [2:0]        c0_d   [TLB_ENTRIES];
    logic [2:0]        c1_q   [TLB_ENTRIES];
    logic [2:0]        c1_d   [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] g_q, g_d, v0_q, v0_d, d0_q, d0_d, v1_q, v1_d, d1_q, d1_d;
    logic [IDX_W-1:0]  wr_idx;

    logic [NUM_PORTS-1:0]    valid_q, valid_d, uncached_q, uncached_d;
    logic [NUM_PORTS-1:0]    addr_err_q, addr_err_d, refill_q, refill_d;
    logic [NUM_PORTS-1:0]    invalid_q, invalid_d, modified_q, modified_d;
    logic [NUM_PORTS*32-1:0] paddr_q, paddr_d;
    logic [31:0]       lu_va;
    logic              lu_hit;
    logic [IDX_W-1:0]  lu_idx;
    logic [19:0]       lu_pfn;
    logic [2:0]        lu_c;
    logic              lu_d, lu_v;

    logic              done_q, done_d;
    logic [31:0]       probe_q, probe_d, ehi_q, ehi_d, elo0_q, elo0_d, elo1_q, elo1_d;
    logic              pr_hit;
    logic [IDX_W-1:0]  pr_idx;
    logic [IDX_W-1:0]  rand_q, rand_d;

    logic              unused_bits;
    assign unused_bits = ^{entryhi_i[12:0], entrylo0_i[31:26], entrylo1_i[31:26]};

    // TLBWR targets the Random value as it stands before the command edge.
    always_comb begin
        vpn2_d = vpn2_q;
        asid_d = asid_q;
        pfn0_d = pfn0_q;
        pfn1_d = pfn1_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        g_d    = g_q;
        v0_d   = v0_q;
        d0_d   = d0_q;
        v1_d   = v1_q;
        d1_d   = d1_q;
        wr_idx = (tlb_op == OP_TLBWR) ? rand_q : index_i;
        if (tlb_op_valid && (tlb_op == OP_TLBWI || tlb_op == OP_TLBWR)) begin
            vpn2_d[wr_idx] = entryhi_i[31:13];
            asid_d[wr_idx] = entryhi_i[ASID_W-1:0];
            g_d[wr_idx]    = entrylo0_i[0] & entrylo1_i[0];
            pfn0_d[wr_idx] = entrylo0_i[25:6];
            c0_d[wr_idx]   = entrylo0_i[5:3];
            d0_d[wr_idx]   = entrylo0_i[2];
            v0_d[wr_idx]   = entrylo0_i[1];
            pfn1_d[wr_idx] = entrylo1_i[25:6];
            c1_d[wr_idx]   = entrylo1_i[5:3];
            d1_d[wr_idx]   = entrylo1_i[2];
            v1_d[wr_idx]   = entrylo1_i[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                pfn0_q[i] <= '0;
                pfn1_q[i] <= '0;
                c0_q[i]   <= '0;
                c1_q[i]   <= '0;
            end
            g_q  <= '0;
            v0_q <= '0;
            d0_q <= '0;
            v1_q <= '0;
            d1_q <= '0;
        end else begin
            vpn2_q <= vpn2_d;
            asid_q <= asid_d;
            pfn0_q <= pfn0_d;
            pfn1_q <= pfn1_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            g_q    <= g_d;
            v0_q   <= v0_d;
            d0_q   <= d0_d;
            v1_q   <= v1_d;
            d1_q   <= d1_d;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        valid_d    = lk_en;
        paddr_d    = '0;
        uncached_d = '0;
        addr_err_d = '0;
        refill_d   = '0;
        invalid_d  = '0;
        modified_d = '0;
        lu_va  = '0;
        lu_hit = 1'b0;
        lu_idx = '0;
        lu_pfn = '0;
        lu_c   = '0;
        lu_d   = 1'b0;
        lu_v   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            lu_va  = lk_vaddr[p*32 +: 32];
            lu_hit = 1'b0;
            lu_idx = '0;
            for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
                if (vpn2_q[i] == lu_va[31:13] && (g_q[i] || asid_q[i] == cur_asid)) begin
                    lu_hit = 1'b1;
                    lu_idx = IDX_W'(i);
                end
            end
            lu_pfn = lu_va[12] ? pfn1_q[lu_idx] : pfn0_q[lu_idx];
            lu_c   = lu_va[12] ? c1_q[lu_idx]   : c0_q[lu_idx];
            lu_d   = lu_va[12] ? d1_q[lu_idx]   : d0_q[lu_idx];
            lu_v   = lu_va[12] ? v1_q[lu_idx]   : v0_q[lu_idx];
            if (lk_en[p]) begin
                if (user_mode && lu_va[31]) begin
                    addr_err_d[p] = 1'b1;
                end else if (lu_va[31:30] == 2'b10) begin
                    paddr_d[p*32 +: 32] = {3'b000, lu_va[28:0]};
                    uncached_d[p]       = lu_va[29] | kseg0_uncached;
                end else if (!lu_hit) begin
                    refill_d[p] = 1'b1;
                end else if (!lu_v) begin
                    invalid_d[p] = 1'b1;
                end else if (lk_store[p] && !lu_d) begin
                    modified_d[p] = 1'b1;
                end else begin
                    paddr_d[p*32 +: 32] = {lu_pfn, lu_va[11:0]};
                    uncached_d[p]       = (lu_c == 3'b010);
                end
            end
        end
    end

    always_comb begin
        done_d  = tlb_op_valid;
        probe_d = probe_q;
        ehi_d   = ehi_q;
        elo0_d  = elo0_q;
        elo1_d  = elo1_q;
        pr_hit  = 1'b0;
        pr_idx  = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (vpn2_q[i] == entryhi_i[31:13] &&
                (g_q[i] || asid_q[i] == entryhi_i[ASID_W-1:0])) begin
                pr_hit = 1'b1;
                pr_idx = IDX_W'(i);
            end
        end
        if (tlb_op_valid && tlb_op == OP_TLBP) begin
            probe_d = pr_hit ? 32'(pr_idx) : 32'h8000_0000;
        end else if (tlb_op_valid && tlb_op == OP_TLBR) begin
            ehi_d                = '0;
            ehi_d[31:13]         = vpn2_q[index_i];
            ehi_d[ASID_W-1:0]    = asid_q[index_i];
            elo0_d = {6'b0, pfn0_q[index_i], c0_q[index_i], d0_q[index_i], v0_q[index_i], g_q[index_i]};
            elo1_d = {6'b0, pfn1_q[index_i], c1_q[index_i], d1_q[index_i], v1_q[index_i], g_q[index_i]};
        end
    end

    // Random reloads after reaching Wired, and parks at the top when Wired leaves no room.
    always_comb begin
        if (wired_we || wired_i >= RAND_MAX || rand_q == wired_i) begin
            rand_d = RAND_MAX;
        end else begin
            rand_d = rand_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            paddr_q    <= '0;
            uncached_q <= '0;
            addr_err_q <= '0;
            refill_q   <= '0;
            invalid_q  <= '0;
            modified_q <= '0;
            done_q     <= 1'b0;
            probe_q    <= '0;
            ehi_q      <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            rand_q     <= RAND_MAX;
        end else begin
            valid_q    <= valid_d;
            paddr_q    <= paddr_d;
            uncached_q <= uncached_d;
            addr_err_q <= addr_err_d;
            refill_q   <= refill_d;
            invalid_q  <= invalid_d;
            modified_q <= modified_d;
            done_q     <= done_d;
            probe_q    <= probe_d;
            ehi_q      <= ehi_d;
            elo0_q     <= elo0_d;
            elo1_q     <= elo1_d;
            rand_q     <= rand_d;
        end
    end

    assign lk_valid      = valid_q;
    assign lk_paddr      = paddr_q;
    assign lk_uncached   = uncached_q;
    assign lk_addr_err   = addr_err_q;
    assign lk_refill     = refill_q;
    assign lk_invalid    = invalid_q;
    assign lk_modified   = modified_q;
    assign tlb_done      = done_q;
    assign probe_index_o = probe_q;
    assign entryhi_o     = ehi_q;
    assign entrylo0_o    = elo0_q;
    assign entrylo1_o    = elo1_q;
    assign random_o      = rand_q;

endmodule
